// File: rtl/cmp_pkg.sv
// cmp_pkg: op encodings and FSM states shared by the compare unit
package cmp_pkg;
  localparam logic [1:0] OP_SLT  = 2'b00;
  localparam logic [1:0] OP_SLTU = 2'b01;
  localparam logic [1:0] OP_SEQ  = 2'b10;
  localparam logic [1:0] OP_ZERO = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
endpackage

// File: rtl/cmp_if.sv
// cmp_if: operand/result valid-ready handshake bundle for cmp_unit
interface cmp_if #(parameter int WIDTH = 32);
  logic in_valid, in_ready, out_valid, out_ready;
  logic [1:0] op;
  logic [WIDTH-1:0] a, b, y;
  modport master (output in_valid, op, a, b, out_ready, input in_ready, out_valid, y);
  modport slave (input in_valid, op, a, b, out_ready, output in_ready, out_valid, y);
endinterface

// File: rtl/cmp_unit_chunk_cmp.sv
// chunk_cmp: one-chunk unsigned compare, MSB flipped for the signed top chunk
module chunk_cmp #(parameter int CHUNK = 8) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             is_signed_top,
  output logic             lt,
  output logic             eq
);
  logic [CHUNK-1:0] m;
  always_comb begin
    m = CHUNK'(is_signed_top) << (CHUNK - 1);
    lt = (a ^ m) < (b ^ m);
    eq = a == b;
  end
endmodule

// File: rtl/cmp_unit.sv
// cmp_unit: multi-cycle MSB-first chunked set-on-compare with early exit
module cmp_unit
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic clk,
  input logic reset,
  cmp_if.slave bus
);
  localparam int N = WIDTH / CHUNK;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  if (WIDTH < 2 || WIDTH % CHUNK != 0) begin : g_bad_width
    $error("cmp_unit: WIDTH must be >= 2 and a multiple of CHUNK");
  end
  state_t state, state_nx;
  logic [WIDTH-1:0] ra, rb;
  logic [1:0] rop;
  logic [IW-1:0] idx;
  logic flag, lt, eq, last;
  chunk_cmp #(.CHUNK(CHUNK)) u_chunk (
    .a(ra[idx*CHUNK +: CHUNK]),
    .b(rb[idx*CHUNK +: CHUNK]),
    .is_signed_top(rop == OP_SLT && idx == IW'(N - 1)),
    .lt(lt),
    .eq(eq)
  );
  assign last = !eq || idx == '0;
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state == S_IDLE ? (bus.in_valid ? (bus.op == OP_ZERO ? S_DONE : S_BUSY) : S_IDLE)
             : state == S_BUSY ? (last ? S_DONE : S_BUSY)
             : (bus.out_ready ? S_IDLE : S_DONE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ra <= '0;
      rb <= '0;
      rop <= OP_SLT;
      idx <= '0;
      flag <= 1'b0;
    end else if (state == S_IDLE && bus.in_valid) begin
      ra <= bus.a;
      rb <= bus.b;
      rop <= bus.op;
      idx <= IW'(N - 1);
      flag <= 1'b0;
    end else if (state == S_BUSY) begin
      if (last) flag <= rop == OP_SEQ ? eq : lt;
      else idx <= idx - IW'(1);
    end
  end
  always_comb begin
    bus.in_ready = state == S_IDLE;
    bus.out_valid = state == S_DONE;
    bus.y = {{(WIDTH - 1){1'b0}}, flag};
  end
endmodule

// File: tb/tb_cmp_unit.sv
// tb_cmp_unit: directed and randomized checks of cmp_unit against a flag/latency model
module tb_cmp_unit;
  import cmp_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  cmp_if #(.WIDTH(32)) bus ();
  cmp_unit #(.WIDTH(32), .CHUNK(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Expected flag from plain integer ordering; latency from the highest differing byte.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] y, output int lat);
    int k = 4;
    for (int i = 0; i < 4; i++)
      if (((a >> (8 * i)) & 32'hff) != ((b >> (8 * i)) & 32'hff)) k = 4 - i;
    if (op == OP_ZERO) begin
      y = 0;
      lat = 1;
    end else begin
      y = op == OP_SLT ? 32'($signed(a) < $signed(b)) : op == OP_SLTU ? 32'(a < b) : 32'(a == b);
      lat = k + 1;
    end
  endfunction
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    chk("in_ready_before_issue", 32'(bus.in_ready), 1);
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op = ~op;
    bus.a = $urandom;
    bus.b = $urandom;
  endtask
  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 30);
  endtask
  task automatic consume(input int stall);
    repeat (stall) @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("consume_out_valid", 32'(bus.out_valid), 0);
    chk("consume_in_ready", 32'(bus.in_ready), 1);
    @(negedge clk);
  endtask
  task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_y, input int exp_lat, input int stall);
    int lat;
    issue(op, a, b);
    wait_result(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_y"}, bus.y, exp_y);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 0);
    consume(stall);
  endtask
  initial begin
    logic [31:0] a, b, ey;
    logic [1:0] op;
    int el, lat;
    logic seen;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op = OP_SLT;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", 32'(bus.in_ready), 1);
    chk("reset_out_valid", 32'(bus.out_valid), 0);
    chk("reset_y", bus.y, 0);
    reset = 1'b0;
    @(negedge clk);
    run("slt_neg_pos", OP_SLT, 32'hFFFFFFFF, 32'h00000001, 1, 2, 0);
    run("sltu_neg_pos", OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 0, 2, 1);
    run("slt_min_one", OP_SLT, 32'h80000000, 32'h00000001, 1, 2, 0);
    run("slt_max_m1", OP_SLT, 32'h7FFFFFFF, 32'hFFFFFFFF, 0, 2, 0);
    run("sltu_early", OP_SLTU, 32'h01000000, 32'h00FFFFFF, 0, 2, 0);
    run("seq_equal", OP_SEQ, 32'h12345678, 32'h12345678, 1, 5, 0);
    run("seq_low_diff", OP_SEQ, 32'h12345678, 32'h12345679, 0, 5, 0);
    run("sltu_low", OP_SLTU, 32'h00000001, 32'h00000002, 1, 5, 2);
    run("slt_both_neg", OP_SLT, 32'hFFFFFFFE, 32'hFFFFFFFF, 1, 5, 0);
    run("zero", OP_ZERO, 32'h00000000, 32'hFFFFFFFF, 0, 1, 0);
    issue(OP_SLT, 32'hFFFFFFFF, 32'h00000001);
    wait_result(lat);
    chk("bp_lat", 32'(lat), 2);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      bus.a = $urandom;
      bus.op = 2'(i);
      @(posedge clk);
      @(negedge clk);
      chk("bp_y", bus.y, 1);
      chk("bp_out_valid", 32'(bus.out_valid), 1);
      chk("bp_in_ready", 32'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    chk("bp_release_in_ready", 32'(bus.in_ready), 1);
    chk("bp_release_out_valid", 32'(bus.out_valid), 0);
    @(negedge clk);
    issue(OP_SEQ, 32'hCAFEF00D, 32'hCAFEF00D);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_out_valid", 32'(bus.out_valid), 0);
    chk("rst_mid_y", bus.y, 0);
    chk("rst_mid_in_ready", 32'(bus.in_ready), 1);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("rst_no_stale", 32'(seen), 0);
    run("slt_after_rst", OP_SLT, 32'd3, 32'd5, 1, 5, 0);
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = a;
        2: b = a ^ (32'h1 << $urandom_range(0, 31));
        default: b = {a[31:16], 16'($urandom)};
      endcase
      model(op, a, b, ey, el);
      run("rand", op, a, b, ey, el, int'($urandom_range(0, 2)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cmp_unit.md
# cmp_unit

Parametrised, multi-cycle set-on-compare unit for the ALU datapath. It replaces the single-cycle, 32-bit-only set-less-than path. It compares two WIDTH-bit operands CHUNK bits per cycle, MSB-first, and exits early on the first differing chunk. Modes are signed less-than, unsigned less-than, equality and forced-zero. Operands enter and results leave over valid/ready handshakes, so the unit can sit behind the register-read stage and ahead of writeback.

## Interface
- WIDTH, 32: operand/result width; must be ≥ 2 and a multiple of CHUNK.
- CHUNK, 8: bits compared per cycle; N = WIDTH/CHUNK.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands/op valid.
- in_ready  out  1  unit can accept; high only in IDLE.
- op  in  2  00 SLT (signed), 01 SLTU (unsigned), 10 SEQ, 11 ZERO.
- A, B  in  WIDTH  operands.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- Y  out  WIDTH  result: flag zero-extended to WIDTH.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid && in_ready, latch A, B and op, and set chunk index idx=N-1.
  - op=ZERO: go to DONE with flag=0.
  - Otherwise: go to BUSY.
- BUSY: compare chunk idx of the latched A and B.
  - Signed mode: in the top chunk only, the operand MSBs are inverted before an unsigned compare. This gives a true signed ordering with no subtraction and no overflow error.
  - Chunk differs: go to DONE. SLT/SLTU flag = (A_chunk < B_chunk); SEQ flag = 0.
  - Chunk equal and idx=0: go to DONE. SLT/SLTU flag = 0; SEQ flag = 1.
  - Chunk equal and idx>0: decrement idx and stay in BUSY.
- DONE: out_valid=1 and Y={WIDTH-1 zeros, flag}. Y and out_valid hold until out_ready. On out_valid && out_ready, go to IDLE. A new input cannot be accepted in that same cycle.
- in_valid, A, B and op are ignored outside IDLE. Latched operands are unaffected by input changes.
- Reset (any state, including mid-BUSY): state=IDLE, in_ready=1, out_valid=0, Y=0, idx=0. Any in-flight operation is discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, Y=0.
- The accept edge is t0.
- ZERO: out_valid rises at edge t0+1.
- Compare: out_valid rises at edge t0+k+1, where k is the number of chunks examined (1…N).
  - Worst case (equal operands, or a difference only in the lowest chunk): N+1 edges.
  - Best case (difference in the top chunk): 2 edges.
- Result consumed at edge tc: out_valid falls and in_ready rises at tc. The next accept is at tc+1 at the earliest.
- Throughput: at most one operation per (k+2) cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package cmp_pkg: op encoding constants (OP_SLT, OP_SLTU, OP_SEQ, OP_ZERO) and the state enum (S_IDLE, S_BUSY, S_DONE).
- Sub-module chunk_cmp: purely combinational.
  - Parameter: CHUNK.
  - Inputs: a, b, is_signed_top.
  - Outputs: lt, eq.
- cmp_unit: holds the FSM, operand registers, idx counter and result register.
- Elaboration-time check: WIDTH % CHUNK == 0.

## Test plan
All scenarios use WIDTH=32, CHUNK=8.
- Sign handling: SLT A=0xFFFFFFFF, B=0x00000001 → Y=1 at t0+2. SLTU with the same operands → Y=0 at t0+2.
- Overflow-prone operands:
  - SLT A=0x80000000, B=0x00000001 → Y=1.
  - SLT A=0x7FFFFFFF, B=0xFFFFFFFF → Y=0.
- Latency:
  - SLTU A=0x01000000, B=0x00FFFFFF → Y=0 at t0+2 (early exit).
  - SEQ A=B=0x12345678 → Y=1 at t0+5.
  - SLTU A=0x00000001, B=0x00000002 → Y=1 at t0+5.
- Backpressure: after the result appears, hold out_ready=0 for 5 cycles while toggling in_valid, A and op. Required: Y and out_valid stable, in_ready=0, no accept. Raise out_ready: in_ready=1 on the next cycle.
- Reset mid-operation: SEQ on equal operands, assert reset at t0+2 for one cycle. Required: next cycle out_valid=0, Y=0, in_ready=1, and no stale result ever appears. A subsequent SLT 3<5 → Y=1.
- ZERO: op=11 with A=0, B=0xFFFFFFFF → Y=0, out_valid at t0+1.
